// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
//   I2C_ADDR_WIDTH / I2C_DATA_WIDTH : address and byte widths
//   I2C_RW_*                        : R/W bit encoding (bit 0 of the address byte)
//   i2c_state_e                     : target FSM states
//   i2c_pulse_t                     : bundle of one-cycle event pulses
package i2c_pkg;

  localparam int unsigned I2C_DATA_WIDTH = 8;
  localparam int unsigned I2C_ADDR_WIDTH = I2C_DATA_WIDTH - 1;
  localparam int unsigned I2C_CNT_WIDTH  = 3;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  typedef struct packed {
    logic rx_valid;
    logic addr_hit;
    logic stop;
    logic nack;
  } i2c_pulse_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus/handshake bundle between the I2C target and its pad + fabric side.
//   slave  : view used by i2c_slave
//   master : view used by whatever drives the pad inputs and consumes bytes
interface i2c_slave_if;
  import i2c_pkg::*;

  logic                      en_i;
  logic [I2C_ADDR_WIDTH-1:0] own_addr_i;
  logic                      scl_i;
  logic                      sda_i;
  logic                      sda_o;
  logic                      sda_t;
  logic [I2C_DATA_WIDTH-1:0] rx_data_o;
  logic                      rx_valid_o;
  logic [I2C_DATA_WIDTH-1:0] tx_data_i;
  logic                      tx_ready_o;
  logic                      busy_o;
  logic                      addr_hit_o;
  logic                      dir_o;
  logic                      stop_o;
  logic                      nack_o;

  modport slave (
    input  en_i, own_addr_i, scl_i, sda_i, tx_data_i,
    output sda_o, sda_t, rx_data_o, rx_valid_o, tx_ready_o,
           busy_o, addr_hit_o, dir_o, stop_o, nack_o
  );

  modport master (
    output en_i, own_addr_i, scl_i, sda_i, tx_data_i,
    input  sda_o, sda_t, rx_data_o, rx_valid_o, tx_ready_o,
           busy_o, addr_hit_o, dir_o, stop_o, nack_o
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus delay register for one pad line, with edge detect.
//   clk_i, a_rst_n_i : clock, async active-low reset
//   i_line           : raw pad level
//   o_level          : synchronized level
//   o_rise_c/o_fall_c: edge strobes (one cycle) of the synchronized level
module i2c_line_sync (
  input  logic clk_i,
  input  logic a_rst_n_i,
  input  logic i_line,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Reset to the idle-bus level so release from reset produces no false edge.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_dly  <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_level  = r_sync;
  assign o_rise_c = r_sync & ~r_dly;
  assign o_fall_c = ~r_sync & r_dly;

endmodule

// File: rtl/i2c_slave.sv
// 7-bit-addressed I2C target: START/STOP detect, address match + ACK,
// write-byte delivery and read-byte service through a byte handshake.
//   clk_i, a_rst_n_i : system clock (>= 10x SCL), async active-low reset
//   bus (slave)      : en_i, own_addr_i, scl_i, sda_i, tx_data_i in;
//                      sda_o/sda_t open-drain pad control, rx_data_o/rx_valid_o,
//                      tx_ready_o, busy_o, addr_hit_o, dir_o, stop_o, nack_o out
module i2c_slave
  import i2c_pkg::*;
(
  input  logic        clk_i,
  input  logic        a_rst_n_i,
  i2c_slave_if.slave  bus
);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync u_scl_sync (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .i_line    (bus.scl_i),
    .o_level   (w_scl_level),
    .o_rise_c  (w_scl_rise),
    .o_fall_c  (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .i_line    (bus.sda_i),
    .o_level   (w_sda_level),
    .o_rise_c  (w_sda_rise),
    .o_fall_c  (w_sda_fall)
  );

  // Bus conditions: SDA edges while SCL is high.
  assign w_start = w_sda_fall & w_scl_level;
  assign w_stop  = w_sda_rise & w_scl_level;

  i2c_state_e                r_state,    w_state_nxt;
  logic [I2C_CNT_WIDTH-1:0]  r_cnt,      w_cnt_nxt;
  logic [I2C_DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
  logic [I2C_ADDR_WIDTH-1:0] r_own_addr, w_own_addr_nxt;
  logic                      r_dir,      w_dir_nxt;
  logic                      r_sda_t,    w_sda_t_nxt;
  logic [I2C_DATA_WIDTH-1:0] r_rx_data,  w_rx_data_nxt;
  logic                      r_busy,     w_busy_nxt;
  i2c_pulse_t                r_pulse,    w_pulse_nxt;
  logic                      w_tx_load;
  logic [I2C_DATA_WIDTH-1:0] w_shift_in;

  assign w_shift_in = {r_shift[I2C_DATA_WIDTH-2:0], w_sda_level};

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_own_addr <= '0;
      r_dir      <= 1'b0;
      r_sda_t    <= 1'b1;
      r_rx_data  <= '0;
      r_busy     <= 1'b0;
      r_pulse    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_own_addr <= w_own_addr_nxt;
      r_dir      <= w_dir_nxt;
      r_sda_t    <= w_sda_t_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_busy     <= w_busy_nxt;
      r_pulse    <= w_pulse_nxt;
    end
  end

  // Next-state logic. Priority: disable, STOP, START, then per-state SCL events.
  // In the ACK states r_cnt marks whether the first SCL fall (begin ACK drive)
  // or the RD_ACK sampling rise has already been seen.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_own_addr_nxt = r_own_addr;
    w_dir_nxt      = r_dir;
    w_sda_t_nxt    = r_sda_t;
    w_rx_data_nxt  = r_rx_data;
    w_busy_nxt     = r_busy;
    w_pulse_nxt    = '0;
    w_tx_load      = 1'b0;

    if (!bus.en_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_sda_t_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
    end else if (w_stop) begin
      w_state_nxt      = ST_IDLE;
      w_cnt_nxt        = '0;
      w_sda_t_nxt      = 1'b1;
      w_busy_nxt       = 1'b0;
      w_pulse_nxt.stop = r_busy;
    end else if (w_start) begin
      w_state_nxt    = ST_ADDR;
      w_cnt_nxt      = '0;
      w_sda_t_nxt    = 1'b1;
      w_busy_nxt     = 1'b1;
      w_own_addr_nxt = bus.own_addr_i;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_sda_t_nxt = 1'b1;
        end

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            if (r_cnt == I2C_CNT_WIDTH'(7)) begin
              w_cnt_nxt = '0;
              if (w_shift_in[I2C_DATA_WIDTH-1:1] == r_own_addr) begin
                w_state_nxt          = ST_ADDR_ACK;
                w_dir_nxt            = w_shift_in[0];
                w_pulse_nxt.addr_hit = 1'b1;
              end else begin
                w_state_nxt = ST_WAIT_STOP;
              end
            end else begin
              w_cnt_nxt = r_cnt + I2C_CNT_WIDTH'(1);
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == '0) begin
              w_sda_t_nxt = 1'b0;
              w_cnt_nxt   = I2C_CNT_WIDTH'(1);
            end else begin
              w_cnt_nxt = '0;
              if (r_dir == I2C_RW_READ) begin
                w_state_nxt = ST_RD_DATA;
                w_tx_load   = 1'b1;
                w_shift_nxt = bus.tx_data_i;
                w_sda_t_nxt = bus.tx_data_i[I2C_DATA_WIDTH-1];
              end else begin
                w_state_nxt = ST_WR_DATA;
                w_sda_t_nxt = 1'b1;
              end
            end
          end
        end

        ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            if (r_cnt == I2C_CNT_WIDTH'(7)) begin
              w_state_nxt          = ST_WR_ACK;
              w_cnt_nxt            = '0;
              w_rx_data_nxt        = w_shift_in;
              w_pulse_nxt.rx_valid = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + I2C_CNT_WIDTH'(1);
            end
          end
        end

        ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == '0) begin
              w_sda_t_nxt = 1'b0;
              w_cnt_nxt   = I2C_CNT_WIDTH'(1);
            end else begin
              w_sda_t_nxt = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_WR_DATA;
            end
          end
        end

        // MSB already on the line from the load; each fall presents the next bit.
        ST_RD_DATA: begin
          if (w_scl_fall) begin
            if (r_cnt == I2C_CNT_WIDTH'(7)) begin
              w_state_nxt = ST_RD_ACK;
              w_cnt_nxt   = '0;
              w_sda_t_nxt = 1'b1;
            end else begin
              w_cnt_nxt   = r_cnt + I2C_CNT_WIDTH'(1);
              w_shift_nxt = {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
              w_sda_t_nxt = r_shift[I2C_DATA_WIDTH-2];
            end
          end
        end

        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_level) begin
              w_state_nxt      = ST_WAIT_STOP;
              w_pulse_nxt.nack = 1'b1;
            end else begin
              w_cnt_nxt = I2C_CNT_WIDTH'(1);
            end
          end else if (w_scl_fall && (r_cnt == I2C_CNT_WIDTH'(1))) begin
            w_state_nxt = ST_RD_DATA;
            w_cnt_nxt   = '0;
            w_tx_load   = 1'b1;
            w_shift_nxt = bus.tx_data_i;
            w_sda_t_nxt = bus.tx_data_i[I2C_DATA_WIDTH-1];
          end
        end

        ST_WAIT_STOP: begin
          w_sda_t_nxt = 1'b1;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_sda_t_nxt = 1'b1;
        end
      endcase
    end
  end

  assign bus.sda_o      = 1'b0;
  assign bus.sda_t      = r_sda_t;
  assign bus.rx_data_o  = r_rx_data;
  assign bus.rx_valid_o = r_pulse.rx_valid;
  assign bus.addr_hit_o = r_pulse.addr_hit;
  assign bus.stop_o     = r_pulse.stop;
  assign bus.nack_o     = r_pulse.nack;
  assign bus.busy_o     = r_busy;
  assign bus.dir_o      = r_dir;
  // Must coincide with the SCL-fall detect cycle in which tx_data_i is captured.
  assign bus.tx_ready_o = w_tx_load;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-level I2C master, open-drain line
// model, event monitor and a transaction-level expectation model.
module tb_i2c_slave;

  localparam int unsigned Q = 20;

  logic clk_i;
  logic a_rst_n_i;
  logic r_scl;
  logic r_msda;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  i2c_slave_if bus ();

  assign bus.scl_i = r_scl;
  assign bus.sda_i = r_msda & (bus.sda_t | bus.sda_o);

  i2c_slave dut (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .bus       (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Event monitor (only writer of these variables).
  int         n_rx = 0, n_hit = 0, n_stop = 0, n_nack = 0, n_txr = 0, n_low = 0;
  logic       last_dir = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         tx_idx = 0;
  logic       tx_pend = 1'b0;

  always @(negedge clk_i) begin
    if (tx_pend) tx_idx <= tx_idx + 1;
    tx_pend <= bus.tx_ready_o;
    if (bus.rx_valid_o) begin
      n_rx <= n_rx + 1;
      rx_q.push_back(bus.rx_data_o);
    end
    if (bus.addr_hit_o) begin
      n_hit    <= n_hit + 1;
      last_dir <= bus.dir_o;
    end
    if (bus.stop_o)     n_stop <= n_stop + 1;
    if (bus.nack_o)     n_nack <= n_nack + 1;
    if (bus.tx_ready_o) n_txr  <= n_txr + 1;
    if (!bus.sda_t)     n_low  <= n_low + 1;
    bus.tx_data_i <= (tx_idx < tx_q.size()) ? tx_q[tx_idx] : 8'hFF;
  end

  initial begin
    repeat (95000) @(posedge clk_i);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- master primitives ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk_i);
  endtask

  task automatic settle();
    wait_q();
    #1;
  endtask

  task automatic m_start();
    if (!r_scl) begin
      r_msda = 1'b1; wait_q();
      r_scl  = 1'b1; wait_q();
    end
    r_msda = 1'b0; wait_q();
    r_scl  = 1'b0; wait_q();
  endtask

  task automatic m_stop();
    r_msda = 1'b0; wait_q();
    r_scl  = 1'b1; wait_q();
    r_msda = 1'b1; wait_q();
  endtask

  task automatic m_bit(input logic b, output logic s);
    r_msda = b;    wait_q();
    r_scl  = 1'b1; wait_q();
    s = bus.sda_i; wait_q();
    r_scl  = 1'b0; wait_q();
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(~ack, s);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [9:0] flags;
    a_rst_n_i = 1'b0;
    bus.en_i = 1'b1;
    bus.own_addr_i = 7'h50;
    r_scl = 1'b1;
    r_msda = 1'b1;
    repeat (5) @(negedge clk_i);
    a_rst_n_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    flags = {bus.sda_o, bus.sda_t, bus.rx_valid_o, bus.tx_ready_o, bus.busy_o,
             bus.addr_hit_o, bus.dir_o, bus.stop_o, bus.nack_o, 1'b0};
    tests++;
    if (flags !== 10'b01_0000_0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want %b", flags, 10'b01_0000_0000);
    end
    tests++;
    if (bus.rx_data_o !== 8'h00) begin
      fails++;
      $display("FAIL reset_rx_data: got %h want 00", bus.rx_data_o);
    end
  endtask

  task automatic test_write();
    int b_rx, b_stop, b_hit;
    logic a0, a1, a2;
    bus.own_addr_i = 7'h50;
    b_rx = n_rx; b_stop = n_stop; b_hit = n_hit;
    m_start();
    #1;
    tests++;
    if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL write_busy: got %b want 1", bus.busy_o); end
    m_write_byte(8'hA0, a0);
    m_write_byte(8'hA5, a1);
    m_write_byte(8'h3C, a2);
    m_stop();
    settle();
    tests++;
    if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
    tests++;
    if (n_rx - b_rx !== 2) begin fails++; $display("FAIL write_rx_count: got %0d want 2", n_rx - b_rx); end
    else begin
      tests++;
      if (rx_q[b_rx] !== 8'hA5 || rx_q[b_rx+1] !== 8'h3C) begin
        fails++; $display("FAIL write_rx_data: got %h %h want a5 3c", rx_q[b_rx], rx_q[b_rx+1]);
      end
    end
    tests++;
    if (n_stop - b_stop !== 1) begin fails++; $display("FAIL write_stop: got %0d want 1", n_stop - b_stop); end
    tests++;
    if (n_hit - b_hit !== 1) begin fails++; $display("FAIL write_hit: got %0d want 1", n_hit - b_hit); end
    tests++;
    if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL write_busy_end: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_mismatch();
    int b_low, b_hit, b_rx;
    logic a0, a1;
    bus.own_addr_i = 7'h50;
    b_low = n_low; b_hit = n_hit; b_rx = n_rx;
    m_start();
    m_write_byte(8'hA2, a0);
    m_write_byte(8'h00, a1);
    #1;
    tests++;
    if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL mismatch_busy: got %b want 1", bus.busy_o); end
    m_stop();
    settle();
    tests++;
    if ({a0, a1} !== 2'b00) begin fails++; $display("FAIL mismatch_acks: got %b want 00", {a0, a1}); end
    tests++;
    if (n_low - b_low !== 0) begin fails++; $display("FAIL mismatch_sda_driven: got %0d cycles want 0", n_low - b_low); end
    tests++;
    if ((n_hit - b_hit) + (n_rx - b_rx) !== 0) begin
      fails++; $display("FAIL mismatch_events: got %0d want 0", (n_hit - b_hit) + (n_rx - b_rx));
    end
    tests++;
    if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL mismatch_busy_end: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_read();
    int b_txr, b_nack;
    logic a;
    logic [7:0] d0, d1;
    bus.own_addr_i = 7'h50;
    tx_q.push_back(8'h96);
    tx_q.push_back(8'h0F);
    b_txr = n_txr; b_nack = n_nack;
    m_start();
    m_write_byte(8'hA1, a);
    m_read_byte(1'b1, d0);
    m_read_byte(1'b0, d1);
    m_stop();
    settle();
    tests++;
    if (a !== 1'b1) begin fails++; $display("FAIL read_addr_ack: got %b want 1", a); end
    tests++;
    if (d0 !== 8'h96 || d1 !== 8'h0F) begin fails++; $display("FAIL read_data: got %h %h want 96 0f", d0, d1); end
    tests++;
    if (n_txr - b_txr !== 2) begin fails++; $display("FAIL read_tx_ready: got %0d want 2", n_txr - b_txr); end
    tests++;
    if (n_nack - b_nack !== 1) begin fails++; $display("FAIL read_nack: got %0d want 1", n_nack - b_nack); end
    tests++;
    if (last_dir !== 1'b1) begin fails++; $display("FAIL read_dir: got %b want 1", last_dir); end
  endtask

  task automatic test_repeated_start();
    int b_rx, b_hit, b_stop;
    logic a0, a1, a2;
    logic [7:0] d;
    bus.own_addr_i = 7'h50;
    tx_q.push_back(8'h5A);
    b_rx = n_rx; b_hit = n_hit; b_stop = n_stop;
    m_start();
    m_write_byte(8'hA0, a0);
    m_write_byte(8'h11, a1);
    m_start();
    m_write_byte(8'hA1, a2);
    m_read_byte(1'b0, d);
    #1;
    tests++;
    if (n_stop - b_stop !== 0) begin fails++; $display("FAIL rs_no_stop: got %0d want 0", n_stop - b_stop); end
    m_stop();
    settle();
    tests++;
    if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL rs_acks: got %b want 111", {a0, a1, a2}); end
    tests++;
    if (n_rx - b_rx !== 1) begin fails++; $display("FAIL rs_rx_count: got %0d want 1", n_rx - b_rx); end
    else begin
      tests++;
      if (rx_q[b_rx] !== 8'h11) begin fails++; $display("FAIL rs_rx_data: got %h want 11", rx_q[b_rx]); end
    end
    tests++;
    if (n_hit - b_hit !== 2 || last_dir !== 1'b1) begin
      fails++; $display("FAIL rs_hits: got %0d dir %b want 2 dir 1", n_hit - b_hit, last_dir);
    end
    tests++;
    if (d !== 8'h5A) begin fails++; $display("FAIL rs_read: got %h want 5a", d); end
  endtask

  task automatic test_partial_stop();
    int b_rx, b_stop;
    logic a, s;
    bus.own_addr_i = 7'($urandom_range(0, 127));
    b_rx = n_rx; b_stop = n_stop;
    m_start();
    m_write_byte({bus.own_addr_i, 1'b0}, a);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), s);
    m_stop();
    settle();
    tests++;
    if (n_rx - b_rx !== 0) begin fails++; $display("FAIL partial_rx: got %0d want 0", n_rx - b_rx); end
    tests++;
    if ({bus.busy_o, bus.sda_t} !== 2'b01) begin
      fails++; $display("FAIL partial_idle: got busy %b sda_t %b want 0 1", bus.busy_o, bus.sda_t);
    end
    tests++;
    if (n_stop - b_stop !== 1) begin fails++; $display("FAIL partial_stop: got %0d want 1", n_stop - b_stop); end
  endtask

  task automatic test_enable();
    int b_rx, b_stop;
    logic a0, a1;
    bus.own_addr_i = 7'h22;
    b_rx = n_rx; b_stop = n_stop;
    m_start();
    m_write_byte(8'h44, a0);
    bus.en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    tests++;
    if ({bus.busy_o, bus.sda_t} !== 2'b01) begin
      fails++; $display("FAIL en_idle: got busy %b sda_t %b want 0 1", bus.busy_o, bus.sda_t);
    end
    bus.en_i = 1'b1;
    m_write_byte(8'h77, a1);
    m_stop();
    settle();
    tests++;
    if ({a0, a1} !== 2'b10) begin fails++; $display("FAIL en_acks: got %b want 10", {a0, a1}); end
    tests++;
    if ((n_rx - b_rx) + (n_stop - b_stop) !== 0) begin
      fails++; $display("FAIL en_events: got %0d want 0", (n_rx - b_rx) + (n_stop - b_stop));
    end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    int k;
    bus.own_addr_i = 7'h50;
    tx_q.push_back(8'($urandom_range(0, 127)));
    m_start();
    m_write_byte(8'hA1, a);
    k = 0;
    while (bus.sda_t !== 1'b0 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    tests++;
    if (bus.sda_t !== 1'b0) begin
      fails++; $display("FAIL rstmid_drive: got sda_t %b want 0 within 200 cycles", bus.sda_t);
    end
    @(posedge clk_i);
    #2;
    a_rst_n_i = 1'b0;
    #1;
    tests++;
    if ({bus.sda_t, bus.busy_o, bus.dir_o, bus.tx_ready_o, bus.rx_data_o} !== {4'b1000, 8'h00}) begin
      fails++;
      $display("FAIL rstmid_outputs: got sda_t %b busy %b dir %b txr %b rx %h want 1 0 0 0 00",
               bus.sda_t, bus.busy_o, bus.dir_o, bus.tx_ready_o, bus.rx_data_o);
    end
    r_scl = 1'b1;
    r_msda = 1'b1;
    repeat (5) @(negedge clk_i);
    a_rst_n_i = 1'b1;
    settle();
  endtask

  // Random transactions; expectations follow from the protocol rules only.
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [6:0] own, addr;
      logic       match, rw, ack;
      int         len;
      int         b_rx, b_hit, b_txr, b_nack, b_stop;
      logic [7:0] d, t[3];
      own   = 7'($urandom_range(0, 127));
      match = ($urandom_range(0, 2) != 0);
      addr  = match ? own : (own ^ 7'($urandom_range(1, 127)));
      rw    = 1'($urandom_range(0, 1));
      len   = $urandom_range(1, 3);
      bus.own_addr_i = own;
      b_rx = n_rx; b_hit = n_hit; b_txr = n_txr; b_nack = n_nack; b_stop = n_stop;
      for (int i = 0; i < 3; i++) t[i] = 8'($urandom_range(0, 255));
      if (match && rw) for (int i = 0; i < len; i++) tx_q.push_back(t[i]);
      m_start();
      m_write_byte({addr, rw}, ack);
      tests++;
      if (ack !== match) begin fails++; $display("FAIL rnd%0d_addr_ack: got %b want %b", it, ack, match); end
      for (int i = 0; i < len; i++) begin
        if (!rw) begin
          m_write_byte(t[i], ack);
          tests++;
          if (ack !== match) begin fails++; $display("FAIL rnd%0d_wr_ack%0d: got %b want %b", it, i, ack, match); end
        end else begin
          m_read_byte(i != len - 1, d);
          tests++;
          if (d !== (match ? t[i] : 8'hFF)) begin
            fails++; $display("FAIL rnd%0d_rd%0d: got %h want %h", it, i, d, match ? t[i] : 8'hFF);
          end
        end
      end
      m_stop();
      settle();
      tests++;
      if (n_hit - b_hit !== int'(match) || (match && last_dir !== rw)) begin
        fails++; $display("FAIL rnd%0d_hit: got %0d dir %b want %0d dir %b", it, n_hit - b_hit, last_dir, match, rw);
      end
      tests++;
      if (n_rx - b_rx !== ((match && !rw) ? len : 0)) begin
        fails++; $display("FAIL rnd%0d_rx_count: got %0d want %0d", it, n_rx - b_rx, (match && !rw) ? len : 0);
      end else if (match && !rw) begin
        for (int i = 0; i < len; i++) begin
          tests++;
          if (rx_q[b_rx+i] !== t[i]) begin
            fails++; $display("FAIL rnd%0d_rx%0d: got %h want %h", it, i, rx_q[b_rx+i], t[i]);
          end
        end
      end
      tests++;
      if (n_txr - b_txr !== ((match && rw) ? len : 0) || n_nack - b_nack !== int'(match && rw)) begin
        fails++; $display("FAIL rnd%0d_rd_events: got txr %0d nack %0d want %0d %0d",
                          it, n_txr - b_txr, n_nack - b_nack, (match && rw) ? len : 0, match && rw);
      end
      tests++;
      if (n_stop - b_stop !== 1 || bus.busy_o !== 1'b0) begin
        fails++; $display("FAIL rnd%0d_stop: got %0d busy %b want 1 busy 0", it, n_stop - b_stop, bus.busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_partial_stop();
    test_enable();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
